// File: rtl/fixed_lut_activation_stream.sv
// Streaming element-wise activation: each lane maps its input code through a
// run-time writable LUT, in a two-stage elastic pipeline with frame-last marking.
module fixed_lut_activation_stream #(
  parameter int DATA_IN_0_PRECISION_0       = 8,
  parameter int DATA_IN_0_PRECISION_1       = 4,
  parameter int DATA_OUT_0_PRECISION_0      = 8,
  parameter int DATA_OUT_0_PRECISION_1      = 4,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 10,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
  parameter int IN_0_DEPTH = (DATA_IN_0_TENSOR_SIZE_DIM_0 + DATA_IN_0_PARALLELISM_DIM_0 - 1)
                             / DATA_IN_0_PARALLELISM_DIM_0,
  parameter     LUT_INIT_FILE = ""
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0 [DATA_IN_0_PARALLELISM_DIM_0],
  input  logic                              data_in_0_valid,
  output logic                              data_in_0_ready,
  output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0 [DATA_IN_0_PARALLELISM_DIM_0],
  output logic                              data_out_0_valid,
  input  logic                              data_out_0_ready,
  output logic                              data_out_0_last,
  input  logic                              lut_wr_en,
  input  logic [DATA_IN_0_PRECISION_0-1:0]  lut_wr_addr,
  input  logic [DATA_OUT_0_PRECISION_0-1:0] lut_wr_data
);

  localparam int NUM_LANES = DATA_IN_0_PARALLELISM_DIM_0;
  localparam int IN_W      = DATA_IN_0_PRECISION_0;
  localparam int OUT_W     = DATA_OUT_0_PRECISION_0;
  localparam int LUT_DEPTH = 2 ** IN_W;
  localparam int CNT_W     = (IN_0_DEPTH > 1) ? $clog2(IN_0_DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(IN_0_DEPTH - 1);

  if (IN_0_DEPTH < 1) begin : g_bad_depth
    $error("IN_0_DEPTH must be at least 1");
  end
  if (DATA_IN_0_PRECISION_1 > DATA_IN_0_PRECISION_0 ||
      DATA_OUT_0_PRECISION_1 > DATA_OUT_0_PRECISION_0) begin : g_bad_frac
    $error("fractional width exceeds total width");
  end

  // One LUT copy per lane so every lane can read in the same cycle.
  logic [OUT_W-1:0] lut_mem [NUM_LANES][LUT_DEPTH];

  always_ff @(posedge clk) begin
    if (lut_wr_en) begin
      for (int unsigned l = 0; l < NUM_LANES; l++) begin
        lut_mem[l][lut_wr_addr] <= lut_wr_data;
      end
    end
  end

  logic [IN_W-1:0]  s1_idx_q [NUM_LANES];
  logic [IN_W-1:0]  s1_idx_d [NUM_LANES];
  logic             s1_valid_q, s1_valid_d;
  logic             s2_valid_q, s2_valid_d;
  logic [OUT_W-1:0] dout_q [NUM_LANES];
  logic [OUT_W-1:0] dout_d [NUM_LANES];
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             en1, en2;

  always_comb begin
    en2             = !s2_valid_q | data_out_0_ready;
    en1             = !s1_valid_q | en2;
    data_in_0_ready = en1 & !lut_wr_en;

    s1_idx_d   = s1_idx_q;
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    dout_d     = dout_q;
    beat_cnt_d = beat_cnt_q;

    if (en1) begin
      s1_idx_d   = data_in_0;
      s1_valid_d = data_in_0_valid & data_in_0_ready;
    end

    // Read happens at the same edge as any pending write, so a collision
    // returns the entry as it was before that write.
    if (en2) begin
      s2_valid_d = s1_valid_q;
      for (int unsigned l = 0; l < NUM_LANES; l++) begin
        dout_d[l] = lut_mem[l][s1_idx_q[l]];
      end
    end

    if (s2_valid_q && data_out_0_ready) begin
      beat_cnt_d = (beat_cnt_q == LAST_BEAT) ? '0 : beat_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_idx_q   <= '{default: '0};
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      dout_q     <= '{default: '0};
      beat_cnt_q <= '0;
    end else begin
      s1_idx_q   <= s1_idx_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      dout_q     <= dout_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign data_out_0       = dout_q;
  assign data_out_0_valid = s2_valid_q;
  assign data_out_0_last  = s2_valid_q & (beat_cnt_q == LAST_BEAT);

endmodule

// File: tb/tb_fixed_lut_activation_stream.sv
// Bench for fixed_lut_activation_stream: scoreboard on a 1-lane, 10-beat-frame
// instance plus a directed table on a 4-lane, 1-beat-frame instance.
module tb_fixed_lut_activation_stream;

  localparam int DEPTH = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din [1];
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] dout [1];
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_last;
  logic       wr_en = 1'b0;
  logic [7:0] wr_addr = '0;
  logic [7:0] wr_data = '0;

  logic [7:0] din4 [4];
  logic       in_valid4 = 1'b0;
  logic       in_ready4;
  logic [7:0] dout4 [4];
  logic       out_valid4;
  logic       out_ready4 = 1'b1;
  logic       out_last4;
  logic       wr_en4 = 1'b0;
  logic [7:0] wr_addr4 = '0;
  logic [7:0] wr_data4 = '0;

  always #5 clk = ~clk;

  fixed_lut_activation_stream #(
    .DATA_IN_0_PRECISION_0(8), .DATA_IN_0_PRECISION_1(4),
    .DATA_OUT_0_PRECISION_0(8), .DATA_OUT_0_PRECISION_1(4),
    .DATA_IN_0_TENSOR_SIZE_DIM_0(10), .DATA_IN_0_PARALLELISM_DIM_0(1)
  ) dut (
    .clk(clk), .rst(rst),
    .data_in_0(din), .data_in_0_valid(in_valid), .data_in_0_ready(in_ready),
    .data_out_0(dout), .data_out_0_valid(out_valid), .data_out_0_ready(out_ready),
    .data_out_0_last(out_last),
    .lut_wr_en(wr_en), .lut_wr_addr(wr_addr), .lut_wr_data(wr_data)
  );

  fixed_lut_activation_stream #(
    .DATA_IN_0_PRECISION_0(8), .DATA_IN_0_PRECISION_1(4),
    .DATA_OUT_0_PRECISION_0(8), .DATA_OUT_0_PRECISION_1(4),
    .DATA_IN_0_TENSOR_SIZE_DIM_0(4), .DATA_IN_0_PARALLELISM_DIM_0(4)
  ) dut4 (
    .clk(clk), .rst(rst),
    .data_in_0(din4), .data_in_0_valid(in_valid4), .data_in_0_ready(in_ready4),
    .data_out_0(dout4), .data_out_0_valid(out_valid4), .data_out_0_ready(out_ready4),
    .data_out_0_last(out_last4),
    .lut_wr_en(wr_en4), .lut_wr_addr(wr_addr4), .lut_wr_data(wr_data4)
  );

  typedef struct { logic [7:0] data; int cyc; } sb_t;
  typedef struct { logic [7:0] din; logic [7:0] dout; } vec1_t;
  typedef struct { logic [7:0] din [4]; logic [7:0] dout [4]; } vec4_t;

  sb_t        sb [$];
  logic [7:0] out_log [$];
  logic [7:0] lut_model [256];
  int         n_vec = 0, n_err = 0;
  int         cyc = 0, out_cnt = 0, outs_seen = 0, n_last = 0;
  bit         lat_chk = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: samples on the falling edge, when the values it sees
  // are the ones the next rising edge will act on.
  initial begin
    bit         stall_prev = 1'b0;
    logic [7:0] prev_data = '0;
    logic       prev_last = 1'b0;
    int         inflight;
    sb_t        e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        sb.delete();
        out_cnt    = 0;
        stall_prev = 1'b0;
      end else begin
        inflight = sb.size();
        if (stall_prev) begin
          chk("hold_valid", {31'd0, out_valid}, 32'd1);
          chk("hold_data", {24'd0, dout[0]}, {24'd0, prev_data});
          chk("hold_last", {31'd0, out_last}, {31'd0, prev_last});
        end
        if (!out_valid) chk("last_without_valid", {31'd0, out_last}, 32'd0);
        if (inflight == 2 && out_valid && !out_ready)
          chk("ready_when_full_stalled", {31'd0, in_ready}, 32'd0);
        if (out_valid && out_ready) begin
          if (inflight == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_beat: got %0h expected no beat (t=%0t)", dout[0], $time);
          end else begin
            e = sb.pop_front();
            chk("data", {24'd0, dout[0]}, {24'd0, e.data});
            chk("last", {31'd0, out_last}, {31'd0, (out_cnt == DEPTH - 1)});
            if (lat_chk) chk("latency", cyc - e.cyc, 32'd2);
          end
          out_log.push_back(dout[0]);
          if (out_last) n_last++;
          outs_seen++;
          out_cnt = (out_cnt == DEPTH - 1) ? 0 : out_cnt + 1;
        end
        stall_prev = out_valid && !out_ready;
        prev_data  = dout[0];
        prev_last  = out_last;
        if (in_valid && in_ready) sb.push_back('{lut_model[din[0]], cyc});
        if (wr_en) lut_model[wr_addr] = wr_data;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    bit done = 1'b0;
    din[0]   = d;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic prog(input logic [7:0] a, input logic [7:0] v);
    wr_en = 1'b1; wr_addr = a; wr_data = v;
    #1 chk("wr_blocks_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", sb.size(), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec1_t tbl1 [4];
    vec4_t tbl4 [2];
    int    lasts_before, sent, guard;
    bit    hs;

    tbl1[0] = '{8'h00, 8'h00};
    tbl1[1] = '{8'h7F, 8'h7F};
    tbl1[2] = '{8'h80, 8'h80};
    tbl1[3] = '{8'hFF, 8'hFF};
    tbl4[0] = '{'{8'h01, 8'h02, 8'h03, 8'h04}, '{8'hFE, 8'hFD, 8'hFC, 8'hFB}};
    tbl4[1] = '{'{8'h00, 8'h7F, 8'h80, 8'hFF}, '{8'hFF, 8'h80, 8'h7F, 8'h00}};
    din[0]  = '0;
    din4    = '{default: '0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    chk("rst_data", {24'd0, dout[0]}, 32'd0);
    chk("rst_data4", {dout4[3], dout4[2], dout4[1], dout4[0]}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1 rst = 1'b0;

    // Identity LUT on the 1-lane unit, inverting LUT on the 4-lane unit
    for (int k = 0; k < 256; k++) begin
      wr_en4 = 1'b1; wr_addr4 = 8'(k); wr_data4 = ~8'(k);
      prog(8'(k), 8'(k));
    end
    wr_en4 = 1'b0;

    // Identity table: back-to-back, 2-cycle latency, no gaps
    out_log.delete();
    lat_chk = 1'b1;
    for (int i = 0; i < 4; i++) send(tbl1[i].din);
    drain();
    lat_chk = 1'b0;
    chk("ident_count", out_log.size(), 32'd4);
    for (int i = 0; i < 4 && i < out_log.size(); i++)
      chk("ident_table", {24'd0, out_log[i]}, {24'd0, tbl1[i].dout});

    // Four lanes in one beat; one-beat frames mark every beat last
    for (int v = 0; v < 2; v++) begin
      chk("ready4", {31'd0, in_ready4}, 32'd1);
      din4 = tbl4[v].din;
      in_valid4 = 1'b1;
      @(posedge clk); #1 in_valid4 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("valid4", {31'd0, out_valid4}, 32'd1);
      chk("last4", {31'd0, out_last4}, 32'd1);
      for (int l = 0; l < 4; l++)
        chk("lane4", {24'd0, dout4[l]}, {24'd0, tbl4[v].dout[l]});
    end

    // Framing: 25 beats -> last on beats 9 and 19 only
    do_reset();
    lasts_before = n_last;
    for (int i = 0; i < 25; i++) send(8'(i));
    drain();
    chk("frame_last_count", n_last - lasts_before, 32'd2);

    // Reset mid-frame at beat 22, then a fresh 10-beat frame
    do_reset();
    outs_seen = 0;
    for (int i = 0; i < 25 && outs_seen < 22; i++) send(8'(i + 100));
    rst = 1'b1;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_last", {31'd0, out_last}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    lasts_before = n_last;
    for (int i = 0; i < 10; i++) send(8'(i + 50));
    drain();
    chk("post_rst_last_count", n_last - lasts_before, 32'd1);

    // Write/read collision: beat in stage 1 reads the old entry
    prog(8'h05, 8'h11);
    out_log.delete();
    send(8'h05);
    prog(8'h05, 8'h22);
    send(8'h05);
    drain();
    chk("collision_count", out_log.size(), 32'd2);
    if (out_log.size() == 2) begin
      chk("collision_old", {24'd0, out_log[0]}, 32'h11);
      chk("collision_new", {24'd0, out_log[1]}, 32'h22);
    end

    // Both stages full and stalled for 5 cycles
    out_log.delete();
    out_ready = 1'b0;
    send(8'h31);
    send(8'h32);
    din[0] = 8'h33;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_ready_low", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(8'h33);
    drain();
    chk("stall_count", out_log.size(), 32'd3);
    for (int i = 0; i < 3 && i < out_log.size(); i++)
      chk("stall_order", {24'd0, out_log[i]}, 32'h31 + i);

    // Random LUT, random valid/ready over 1000 beats
    for (int k = 0; k < 256; k++) prog(8'(k), 8'($urandom));
    sent = 0;
    guard = 0;
    while (sent < 1000 && guard < 20000) begin
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      guard++;
      if (hs) sent++;
      if (!in_valid || hs) begin
        in_valid = ($urandom_range(0, 1) == 1) && (sent < 1000);
        din[0]   = 8'($urandom);
      end
      out_ready = ($urandom_range(0, 1) == 1);
    end
    chk("random_all_sent", sent, 32'd1000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
